noc_traffic_endpoint: RTL and testbench
=======================================

# noc_traffic_endpoint

Synthesizable per-node traffic generator and checker that attaches to one node port of the 4D mesh NoC (all virtual channels of that node). It injects self-describing packets with configurable destination policy and length, and checks every packet it receives for addressing, payload integrity and framing. Sixteen instances, one per node, replace the undriven bench stimulus and form a self-checking regression fabric.

## Interface
- FLIT_WIDTH, 34, flit width in bits; must be ≥ 2·DW+24
- CHANNELS, 9, number of virtual channels
- NODES, 16, node count; DW = $clog2(NODES)
- NODE_ID, 0, this endpoint's node index
- PKT_LEN, 4, flits per packet including header; 2..255
- DEST_MODE, 0, 0 = fixed_dest, 1 = round-robin over other nodes, 2 = LFSR
- GAP, 0, idle cycles between packets; 0..255

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- start  in  1  launch pulse, sampled only in IDLE
- num_packets  in  16  packets to send per launch
- fixed_dest  in  DW  destination for mode 0 and LFSR fallback
- out_flit  out  CHANNELS×FLIT_WIDTH  to NoC in_flit
- out_last / out_valid  out  CHANNELS  to NoC in_last / in_valid
- out_ready  in  CHANNELS  from NoC in_ready
- in_flit  in  CHANNELS×FLIT_WIDTH  from NoC out_flit
- in_last / in_valid  in  CHANNELS  from NoC out_last / out_valid
- in_ready  out  CHANNELS  to NoC out_ready
- busy / done  out  1  generator active / launch complete (held until next start)
- tx_count / rx_count  out  32  packets sent / packets received error-free
- err_count  out  16  checker error cycles, saturating at 0xFFFF
- err  out  1  sticky, set on first error

## Operation
- Header flit: [FW-1 -: DW] = dest, next DW = NODE_ID, next 8 = channel index, [15:0] = seq (16-bit, increments per packet, wraps). Other bits 0.
- Payload flit i (1..PKT_LEN-1) = header XOR i (i zero-extended); out_last only on flit PKT_LEN-1.
- Generator FSM: IDLE → (start) HEAD → BODY (per flit) → GAP (if GAP>0) → HEAD, or → DONE after num_packets packets. start with num_packets=0: IDLE → DONE. DONE → IDLE next cycle; done stays 1 until next accepted start. start outside IDLE ignored.
- Channel: round-robin per packet, starting 0, wraps at CHANNELS-1; exactly one out_valid bit at a time.
- Mode 1: dest = previous+1 mod NODES, skipping NODE_ID; first dest = (NODE_ID+1) mod NODES.
- Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1, advanced once per packet; dest = lfsr[DW-1:0], replaced by fixed_dest if ≥ NODES or == NODE_ID.
- Checker, one FSM per channel: HDR → BODY → HDR; DROP on framing loss. in_ready constantly 1 outside reset.
  - HDR: error if dest ≠ NODE_ID or in_last=1 (stays HDR); else latch header, idx=1.
  - BODY: error if flit ≠ header XOR idx (packet marked bad, continues); last before idx=PKT_LEN-1 → error, → HDR; no last at idx=PKT_LEN-1 → error, → DROP.
  - DROP: discard until in_last, then HDR.
  - Good packet completion: rx_count += number of channels completing that cycle.
- err_count +1 per cycle with ≥1 error on any channel.

## Timing
- Reset: all outputs 0 except in_ready = 0 during reset, 1 from first cycle after release; seq=0, LFSR=0xACE1, channel pointer 0, all FSMs HDR/IDLE.
- Header out_valid rises the cycle after start is sampled; busy rises with it.
- Flits registered; valid/flit/last held stable until valid&ready; next flit presented the cycle after handshake (no bubble, 1 flit/cycle under ready=1).
- GAP cycles counted from last-flit handshake; tx_count increments in that same cycle.
- Checker samples on in_valid (ready=1); counters and err update one cycle after the offending/closing flit.
- Reset asserted mid-packet: outputs clear asynchronously; partial packets abandoned.

## Test plan
- Loopback NODE_ID=3, DEST_MODE=0, fixed_dest=3, PKT_LEN=4, num_packets=10, ready=1 → 40 flits in 40 cycles, channels 0..8,0; tx=rx=10, err=0, done=1.
- out_ready toggled 50% random → flit values held across stalls; tx=10, no reordering of payload.
- Mode 1, NODE_ID=0, 5 packets → dests 1,2,3,4,5; mode 2 → first dest = 0xACE1[3:0]=1.
- Inject corrupted payload flit 2 on channel 4 → err_count=1, err=1, rx_count unchanged for that packet.
- Missing last at flit 3 then last on flit 5 → one error, DROP until flit 5, next packet accepted clean.
- Assert rst mid-packet with num_packets=3 → all outputs 0, restart sends seq 0 on channel 0.

Source files
------------

// File: rtl/noc_traffic_endpoint_if.sv
// Flit link bundle between an endpoint and one NoC node port, all virtual channels side by side.
// A flit moves on a channel in a cycle where that channel's valid and ready are both 1; the sender keeps flit/last/valid stable until then.
interface noc_traffic_endpoint_if #(
  parameter int CHANNELS   = 9,
  parameter int FLIT_WIDTH = 34
) ();
  logic [CHANNELS*FLIT_WIDTH-1:0] flit;
  logic [CHANNELS-1:0]            last;
  logic [CHANNELS-1:0]            valid;
  logic [CHANNELS-1:0]            ready;

  modport master (output flit, output last, output valid, input ready);
  modport slave  (input flit, input last, input valid, output ready);
endinterface

// File: rtl/noc_traffic_endpoint.sv
// Per-node traffic generator (self-describing packets, round-robin channels) and per-channel packet checker.
// Packet = header {dest, src, channel, seq} followed by PKT_LEN-1 payload flits equal to header XOR flit index.
module noc_traffic_endpoint #(
  parameter int FLIT_WIDTH = 34,
  parameter int CHANNELS   = 9,
  parameter int NODES      = 16,
  parameter int NODE_ID    = 0,
  parameter int PKT_LEN    = 4,
  parameter int DEST_MODE  = 0,
  parameter int GAP        = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                num_packets,
  input  logic [$clog2(NODES)-1:0]   fixed_dest,
  noc_traffic_endpoint_if.master     tx,
  noc_traffic_endpoint_if.slave      rx,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                tx_count,
  output logic [31:0]                rx_count,
  output logic [15:0]                err_count,
  output logic                       err,
  output logic [2:0]                 gen_state,
  output logic [2*CHANNELS-1:0]      chk_state_flat
);
  localparam int DW = $clog2(NODES);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  typedef enum logic [2:0] {G_IDLE, G_HEAD, G_BODY, G_GAP, G_DONE} gen_state_t;
  typedef enum logic [1:0] {C_HDR, C_BODY, C_DROP} chk_state_t;

  gen_state_t            state;
  logic [FLIT_WIDTH-1:0] hdr_q, flit_q, hdr_new;
  logic                  valid_q, last_q, hs, launch;
  logic [CW-1:0]         ch_ptr, cur_ch, ch_next;
  logic [7:0]            idx, gap_cnt;
  logic [15:0]           seq, lfsr, pkt_left;
  logic [DW-1:0]         rr_dest, rr_next, dest_sel;

  function automatic logic [FLIT_WIDTH-1:0] make_hdr(logic [DW-1:0] d, logic [CW-1:0] c, logic [15:0] s);
    logic [FLIT_WIDTH-1:0] h;
    h = '0;
    h[FLIT_WIDTH-1 -: DW]        = d;
    h[FLIT_WIDTH-1-DW -: DW]     = DW'(NODE_ID);
    h[FLIT_WIDTH-1-2*DW -: 8]    = 8'(c);
    h[15:0]                      = s;
    return h;
  endfunction

  always_comb begin
    logic [31:0] lf, n;
    lf = 32'(lfsr[DW-1:0]);
    n  = 32'(rr_dest) + 32'd1;
    if (n >= NODES) n = '0;
    if (n == NODE_ID) n = n + 32'd1;
    if (n >= NODES) n = '0;
    rr_next  = DW'(n);
    dest_sel = fixed_dest;
    if (DEST_MODE == 1) dest_sel = rr_dest;
    else if (DEST_MODE == 2 && !(lf >= NODES || lf == NODE_ID)) dest_sel = lfsr[DW-1:0];
    ch_next = (ch_ptr == CW'(CHANNELS-1)) ? '0 : ch_ptr + 1'b1;
    hdr_new = make_hdr(dest_sel, ch_ptr, seq);
    hs      = valid_q & tx.ready[cur_ch];
    // A new header is loaded on start, straight after a last flit when GAP=0, or when the gap expires.
    launch  = (state == G_IDLE && start && num_packets != 16'd0) ||
              (state == G_BODY && hs && last_q && pkt_left != 16'd1 && GAP == 0) ||
              (state == G_GAP && gap_cnt == 8'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= G_IDLE; hdr_q <= '0; flit_q <= '0; valid_q <= 1'b0; last_q <= 1'b0;
      ch_ptr <= '0; cur_ch <= '0; idx <= '0; gap_cnt <= '0; seq <= '0; lfsr <= 16'hACE1;
      pkt_left <= '0; rr_dest <= DW'((NODE_ID + 1) % NODES);
      busy <= 1'b0; done <= 1'b0; tx_count <= '0;
    end else begin
      case (state)
        G_IDLE: if (start) begin
          done     <= 1'b0;
          pkt_left <= num_packets;
          if (num_packets == 16'd0) begin state <= G_DONE; done <= 1'b1; end
        end
        G_HEAD: if (hs) begin
          idx    <= 8'd1;
          flit_q <= hdr_q ^ FLIT_WIDTH'(1);
          last_q <= (LAST_IDX == 8'd1);
          state  <= G_BODY;
        end
        G_BODY: if (hs) begin
          if (last_q) begin
            tx_count <= tx_count + 32'd1;
            pkt_left <= pkt_left - 16'd1;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            if (pkt_left == 16'd1) begin state <= G_DONE; done <= 1'b1; busy <= 1'b0; end
            else begin state <= G_GAP; gap_cnt <= 8'(GAP - 1); end
          end else begin
            idx    <= idx + 8'd1;
            flit_q <= hdr_q ^ FLIT_WIDTH'(idx + 8'd1);
            last_q <= (idx + 8'd1 == LAST_IDX);
          end
        end
        G_GAP:   gap_cnt <= gap_cnt - 8'd1;
        G_DONE:  state <= G_IDLE;
        default: state <= G_IDLE;
      endcase
      if (launch) begin
        state   <= G_HEAD;
        hdr_q   <= hdr_new;
        flit_q  <= hdr_new;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
        busy    <= 1'b1;
        cur_ch  <= ch_ptr;
        ch_ptr  <= ch_next;
        seq     <= seq + 16'd1;
        lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        rr_dest <= rr_next;
      end
    end
  end

  assign tx.flit   = {CHANNELS{flit_q}};
  assign tx.valid  = valid_q ? (CHANNELS'(1) << cur_ch) : '0;
  assign tx.last   = (valid_q && last_q) ? (CHANNELS'(1) << cur_ch) : '0;
  assign gen_state = state;

  chk_state_t            chk_state [CHANNELS];
  logic [FLIT_WIDTH-1:0] chk_hdr   [CHANNELS];
  logic [7:0]            chk_idx   [CHANNELS];
  logic                  chk_bad   [CHANNELS];
  logic [FLIT_WIDTH-1:0] lane      [CHANNELS];
  logic [CHANNELS-1:0]   in_ready_q, fire, ch_err, ch_good, ch_mism;

  always_comb begin
    fire    = rx.valid & in_ready_q;
    ch_err  = '0;
    ch_good = '0;
    ch_mism = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane[c]    = rx.flit[c*FLIT_WIDTH +: FLIT_WIDTH];
      ch_mism[c] = lane[c] != (chk_hdr[c] ^ FLIT_WIDTH'(chk_idx[c]));
      chk_state_flat[2*c +: 2] = chk_state[c];
      if (fire[c]) begin
        if (chk_state[c] == C_HDR)
          ch_err[c] = (lane[c][FLIT_WIDTH-1 -: DW] != DW'(NODE_ID)) || rx.last[c];
        else if (chk_state[c] == C_BODY) begin
          ch_err[c]  = ch_mism[c] || (rx.last[c] != (chk_idx[c] == LAST_IDX));
          ch_good[c] = rx.last[c] && chk_idx[c] == LAST_IDX && !ch_mism[c] && !chk_bad[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        chk_state[c] <= C_HDR; chk_hdr[c] <= '0; chk_idx[c] <= '0; chk_bad[c] <= 1'b0;
      end
      in_ready_q <= '0; rx_count <= '0; err_count <= '0; err <= 1'b0;
    end else begin
      in_ready_q <= '1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (fire[c]) begin
          case (chk_state[c])
            C_HDR: if (!ch_err[c]) begin
              chk_hdr[c] <= lane[c]; chk_idx[c] <= 8'd1; chk_bad[c] <= 1'b0; chk_state[c] <= C_BODY;
            end
            // Data errors only mark the packet bad; framing errors end it.
            C_BODY: begin
              if (rx.last[c])                  chk_state[c] <= C_HDR;
              else if (chk_idx[c] == LAST_IDX) chk_state[c] <= C_DROP;
              else begin
                chk_idx[c] <= chk_idx[c] + 8'd1;
                if (ch_mism[c]) chk_bad[c] <= 1'b1;
              end
            end
            default: if (rx.last[c]) chk_state[c] <= C_HDR;
          endcase
        end
      end
      rx_count <= rx_count + 32'($countones(ch_good));
      if (|ch_err) begin
        err <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  assign rx.ready = in_ready_q;
endmodule

// File: tb/tb_noc_traffic_endpoint.sv
// Bench for noc_traffic_endpoint: loopback node 3 plus two generator-only nodes exercising the destination policies.
module tb_noc_traffic_endpoint;
  localparam int FW = 34;
  localparam int CH = 9;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int lane_of(logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) if (v[i]) return i;
    return 0;
  endfunction

  // node 3, fixed destination, loopback or injected receive traffic
  logic start_a = 0, done_a, busy_a, err_a, loop_en = 1, rand_rdy = 0;
  logic [15:0] num_a = 0, errc_a;
  logic [3:0] fixed_a = 4'd3;
  logic [31:0] tx_a, rx_a;
  logic [2:0] gs_a;
  logic [2*CH-1:0] cs_a;
  logic [CH-1:0] rdy_a = '1, inj_valid = '0, inj_last = '0;
  logic [CH*FW-1:0] inj_flit = '0;
  noc_traffic_endpoint_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) a_tx ();
  noc_traffic_endpoint_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) a_rx ();
  assign a_tx.ready = rdy_a;
  assign a_rx.flit  = loop_en ? a_tx.flit : inj_flit;
  assign a_rx.valid = loop_en ? (a_tx.valid & a_tx.ready) : inj_valid;
  assign a_rx.last  = loop_en ? (a_tx.last & a_tx.ready) : inj_last;

  noc_traffic_endpoint #(.NODE_ID(3), .DEST_MODE(0), .PKT_LEN(4), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_packets(num_a), .fixed_dest(fixed_a),
    .tx(a_tx), .rx(a_rx), .busy(busy_a), .done(done_a), .tx_count(tx_a), .rx_count(rx_a),
    .err_count(errc_a), .err(err_a), .gen_state(gs_a), .chk_state_flat(cs_a));

  // node 0 round-robin (b) and LFSR (c), receive side idle
  logic start_bc = 0, done_b, busy_b, err_b, done_c, busy_c, err_c;
  logic [15:0] num_b = 18, num_c = 20, errc_b, errc_c;
  logic [31:0] tx_b, rx_b, tx_c, rx_c;
  logic [2:0] gs_b, gs_c;
  logic [2*CH-1:0] cs_b, cs_c;
  noc_traffic_endpoint_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) b_tx ();
  noc_traffic_endpoint_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) b_rx ();
  noc_traffic_endpoint_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) c_tx ();
  noc_traffic_endpoint_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) c_rx ();
  assign b_tx.ready = '1; assign b_rx.flit = '0; assign b_rx.last = '0; assign b_rx.valid = '0;
  assign c_tx.ready = '1; assign c_rx.flit = '0; assign c_rx.last = '0; assign c_rx.valid = '0;

  noc_traffic_endpoint #(.NODE_ID(0), .DEST_MODE(1), .PKT_LEN(2), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_bc), .num_packets(num_b), .fixed_dest(4'd7),
    .tx(b_tx), .rx(b_rx), .busy(busy_b), .done(done_b), .tx_count(tx_b), .rx_count(rx_b),
    .err_count(errc_b), .err(err_b), .gen_state(gs_b), .chk_state_flat(cs_b));
  noc_traffic_endpoint #(.NODE_ID(0), .DEST_MODE(2), .PKT_LEN(2), .GAP(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_bc), .num_packets(num_c), .fixed_dest(4'd5),
    .tx(c_tx), .rx(c_rx), .busy(busy_c), .done(done_c), .tx_count(tx_c), .rx_count(rx_c),
    .err_count(errc_c), .err(err_c), .gen_state(gs_c), .chk_state_flat(cs_c));

  // scoreboard queues and reference-model state
  logic [FW-1:0] exp_q[$];
  logic [3:0]    exp_ch_q[$], exp_dest_b[$], exp_dest_c[$];
  logic          exp_last_q[$];
  int m_seq = 0, m_ch = 0, busy_cyc = 0;

  task automatic push_a(int n);
    logic [FW-1:0] hdr;
    for (int k = 0; k < n; k++) begin
      hdr = {4'd3, 4'd3, 8'(m_ch), 2'b00, 16'(m_seq)};
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(hdr ^ FW'(i));
        exp_ch_q.push_back(4'(m_ch));
        exp_last_q.push_back(i == 3);
      end
      m_seq = (m_seq + 1) % 65536;
      m_ch  = (m_ch + 1) % CH;
    end
  endtask

  always @(negedge clk) if (busy_a) busy_cyc++;

  // monitor for node 3 transmit side, including stability across stalls
  logic hold_pending = 0;
  logic [FW-1:0] held_flit;
  logic [CH-1:0] held_valid;
  int held_lane;
  always @(negedge clk) begin
    int ln;
    if (!rst) hold_pending = 0;
    else begin
      if (hold_pending) begin
        check("hold_valid", 64'(a_tx.valid), 64'(held_valid));
        check("hold_flit", 64'(a_tx.flit[held_lane*FW +: FW]), 64'(held_flit));
      end
      ln = lane_of(a_tx.valid);
      hold_pending = |(a_tx.valid & ~a_tx.ready);
      held_lane = ln; held_valid = a_tx.valid; held_flit = a_tx.flit[ln*FW +: FW];
      if (|(a_tx.valid & a_tx.ready)) begin
        if (exp_q.size() == 0) check("a_unexpected_flit", 64'(a_tx.valid), 64'd0);
        else begin
          check("a_onehot", 64'($onehot(a_tx.valid)), 64'd1);
          check("a_chan", 64'(ln), 64'(exp_ch_q.pop_front()));
          check("a_flit", 64'(a_tx.flit[ln*FW +: FW]), 64'(exp_q.pop_front()));
          check("a_last", 64'(a_tx.last[ln]), 64'(exp_last_q.pop_front()));
        end
      end
    end
  end

  // header-destination monitors for nodes b and c (PKT_LEN=2: a flit without last is a header)
  int b_last_cyc = -1;
  always @(negedge clk) begin
    int ln;
    ln = lane_of(b_tx.valid);
    if (rst && |(b_tx.valid & b_tx.ready)) begin
      if (!b_tx.last[ln]) begin
        if (b_last_cyc >= 0) check("b_gap", 64'(cyc - b_last_cyc), 64'd2);
        if (exp_dest_b.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else check("b_dest", 64'(b_tx.flit[ln*FW + FW-4 +: 4]), 64'(exp_dest_b.pop_front()));
      end else b_last_cyc = cyc;
    end
  end
  always @(negedge clk) begin
    int ln;
    ln = lane_of(c_tx.valid);
    if (rst && |(c_tx.valid & c_tx.ready) && !c_tx.last[ln]) begin
      if (exp_dest_c.size() == 0) check("c_unexpected", 64'd1, 64'd0);
      else check("c_dest", 64'(c_tx.flit[ln*FW + FW-4 +: 4]), 64'(exp_dest_c.pop_front()));
    end
  end

  initial forever begin
    @(posedge clk); #1;
    rdy_a = rand_rdy ? CH'($urandom_range(0, (1 << CH) - 1)) : '1;
  end

  task automatic launch_a(int n);
    @(posedge clk); #1;
    num_a = 16'(n); start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
  endtask

  task automatic wait_done_a(int limit);
    int n = 0;
    while (!done_a && n < limit) begin @(posedge clk); #1; n++; end
    check("a_done_in_time", 64'(done_a), 64'd1);
  endtask

  // same packet on every channel in mask; optional corrupted flit and misplaced last
  task automatic send_pkt(logic [CH-1:0] mask, int corrupt, int last_at, int nflits, logic [3:0] dest);
    logic [FW-1:0] hdr, f;
    hdr = {dest, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 8)), 2'b00, 16'($urandom_range(0, 65535))};
    for (int i = 0; i < nflits; i++) begin
      f = hdr ^ FW'(i);
      if (i == corrupt) f = f ^ FW'(34'h100);
      for (int c = 0; c < CH; c++) inj_flit[c*FW +: FW] = mask[c] ? f : '0;
      inj_valid = mask;
      inj_last  = (i == last_at) ? mask : '0;
      @(posedge clk); #1;
    end
    inj_valid = '0; inj_last = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [15:0] lf;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 64'(a_tx.valid), 64'd0);
    check("rst_in_ready", 64'(a_rx.ready), 64'd0);
    check("rst_busy_done", 64'({busy_a, done_a, err_a}), 64'd0);
    check("rst_counts", 64'(tx_a | rx_a | 32'(errc_a)), 64'd0);
    rst = 1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(a_rx.ready), 64'h1FF);

    launch_a(0);
    check("zero_pkt_done", 64'(done_a), 64'd1);
    check("zero_pkt_idle", 64'({busy_a, |a_tx.valid}), 64'd0);

    // loopback at full rate
    push_a(10); busy_cyc = 0;
    launch_a(10);
    check("head_valid_next_cycle", 64'({busy_a, a_tx.valid}), 64'({1'b1, 9'h001}));
    wait_done_a(400);
    check("t1_busy_cycles", 64'(busy_cyc), 64'd40);
    check("t1_tx", 64'(tx_a), 64'd10);
    check("t1_rx", 64'(rx_a), 64'd10);
    check("t1_err", 64'({err_a, errc_a}), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // loopback with random backpressure
    push_a(10); rand_rdy = 1;
    launch_a(10);
    wait_done_a(3000);
    rand_rdy = 0;
    check("t2_tx", 64'(tx_a), 64'd20);
    check("t2_rx", 64'(rx_a), 64'd20);
    check("t2_err", 64'({err_a, errc_a}), 64'd0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // injected receive traffic
    loop_en = 0;
    send_pkt(9'h010, 2, 3, 4, 4'd3);
    check("corrupt_errc", 64'(errc_a), 64'd1);
    check("corrupt_err", 64'(err_a), 64'd1);
    check("corrupt_rx", 64'(rx_a), 64'd20);
    send_pkt(9'h010, -1, 3, 4, 4'd3);
    check("clean_after_corrupt_rx", 64'(rx_a), 64'd21);
    send_pkt(9'h040, -1, 5, 6, 4'd3);
    check("missing_last_errc", 64'(errc_a), 64'd2);
    check("missing_last_rx", 64'(rx_a), 64'd21);
    send_pkt(9'h042, -1, 3, 4, 4'd3);
    check("dual_completion_rx", 64'(rx_a), 64'd23);
    check("dual_completion_errc", 64'(errc_a), 64'd2);
    send_pkt(9'h001, -1, 9, 1, 4'd5);
    check("wrong_dest_errc", 64'(errc_a), 64'd3);
    send_pkt(9'h001, -1, 3, 4, 4'd3);
    check("after_wrong_dest_rx", 64'(rx_a), 64'd24);
    send_pkt(9'h004, -1, 1, 2, 4'd3);
    check("early_last_errc", 64'(errc_a), 64'd4);
    send_pkt(9'h004, -1, 3, 4, 4'd3);
    check("after_early_last_rx", 64'(rx_a), 64'd25);
    check("err_sticky", 64'(err_a), 64'd1);

    // reset in the middle of a launch
    loop_en = 1;
    push_a(3);
    launch_a(3);
    repeat (5) @(posedge clk); #2;
    rst = 0; #1;
    check("midrst_valid", 64'({a_tx.valid, a_tx.last}), 64'd0);
    check("midrst_in_ready", 64'(a_rx.ready), 64'd0);
    check("midrst_status", 64'({busy_a, done_a, err_a}), 64'd0);
    check("midrst_counts", 64'(tx_a | rx_a | 32'(errc_a)), 64'd0);
    exp_q.delete(); exp_ch_q.delete(); exp_last_q.delete();
    m_seq = 0; m_ch = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    push_a(1);
    launch_a(1);
    check("restart_channel0", 64'(a_tx.valid), 64'h001);
    wait_done_a(100);
    check("restart_tx_rx", 64'({tx_a, rx_a}), {32'd1, 32'd1});
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    // destination policies: round-robin skipping self, LFSR with fixed fallback
    d = 0;
    for (int k = 0; k < 18; k++) begin
      d = (d + 1) % 16;
      if (d == 0) d = 1;
      exp_dest_b.push_back(4'(d));
    end
    lf = 16'hACE1;
    for (int k = 0; k < 20; k++) begin
      exp_dest_c.push_back((lf[3:0] == 4'd0) ? 4'd5 : lf[3:0]);
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
    end
    @(posedge clk); #1; start_bc = 1;
    @(posedge clk); #1; start_bc = 0;
    for (int n = 0; n < 400 && !(done_b && done_c); n++) begin @(posedge clk); #1; end
    check("bc_done", 64'({done_b, done_c}), 64'd3);
    check("b_tx", 64'(tx_b), 64'd18);
    check("c_tx", 64'(tx_c), 64'd20);
    check("b_queue_empty", 64'(exp_dest_b.size()), 64'd0);
    check("c_queue_empty", 64'(exp_dest_c.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
